gpio_mmio: RTL and testbench
============================

Name: gpio_mmio

Overview:
- Memory-mapped GPIO peripheral on the CPU data bus; feeds the core's load path and drives the board LEDs.
- Sits between the raw board I/O (i_button, o_led) and the CPU load/store unit.
- Synchronises and debounces the active-low push button, latches press events, counts presses and holds the LED output register.

Parameters:
- LED_W, 6, number of LED outputs.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a new button level; override for silicon.
- CNT_W, 16, width of the press counter.
- LED_RESET, 6'b111111, LED register value after reset (LEDs are active-low, so all off).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- i_addr  in  4  byte address within the peripheral; bits[1:0] are ignored.
- i_we  in  1  write strobe, one cycle per access.
- i_re  in  1  read strobe, one cycle per access.
- i_wdata  in  32  write data.
- o_rdata  out  32  registered read data.
- o_rvalid  out  1  read data valid.
- i_button  in  1  raw board button, asynchronous, active-low (idle 1).
- o_led  out  LED_W  LED drive, direct from the LED register.
- o_irq  out  1  press interrupt (see Optional Feature).

Behaviour:
- Reset values: o_led=LED_RESET, o_rdata=0, o_rvalid=0, o_irq=0, sync flops=1, debounced level=released, counter=0, event=0, irq_en=0.
- Register map (i_addr[3:2]):
  - 0x0 LED: RW, bits[LED_W-1:0]; upper bits read 0.
  - 0x4 STATUS: RO; bit0 = debounced pressed (1 = pressed); bits[16+CNT_W-1:16] = press count. Writes are ignored.
  - 0x8 EVENT: bit0 is a sticky press flag; writing 1 to bit0 clears it (W1C).
  - 0xC IRQ_EN: RW bit0.
- Synchroniser: 2 flops on i_button. The pressed level is the inverted output of flop 2.
- Debounce:
  - Counter resets to 0 whenever the synchronised level equals the debounced level.
  - Otherwise the counter increments each cycle.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - Release-to-press latency: 2 + DEBOUNCE_CYCLES cycles from the i_button edge.
  - A glitch shorter than DEBOUNCE_CYCLES is filtered out.
- Press event: a one-cycle rising edge of the debounced pressed level sets EVENT and increments the counter.
  - Counter wraps 2^CNT_W-1 to 0.
  - Release causes no event.
- Writes take effect at the next clock edge; o_led updates on the same edge.
- Reads:
  - Latency 1: o_rvalid=1 and o_rdata valid in the cycle after i_re.
  - o_rvalid=0 and o_rdata=0 otherwise.
- Simultaneous events:
  - Read and write to the same address in one cycle: the read returns the pre-write value.
  - W1C and a new press event in the same cycle: set wins, EVENT=1.
  - Reading EVENT does not clear it.
- Reset mid-debounce abandons the count; the button is treated as released until it is re-qualified.

Optional Feature:
- Macro: GPIO_IRQ_EN.
- Defined: IRQ_EN register is implemented; o_irq = EVENT & irq_en, registered, so it is 1 cycle late relative to EVENT.
- Undefined: IRQ_EN reads 0 and writes to it are ignored; o_irq is tied to 0; no irq logic is synthesised.

Decomposition:
- Package gpio_pkg holds:
  - register offset constants (ADDR_LED, ADDR_STATUS, ADDR_EVENT, ADDR_IRQEN);
  - the EVENT bit index;
  - the LED_RESET default.
- Sub-module button_debounce (sync + counter + debounced level + press-edge pulse).
- The bus decode and registers stay in gpio_mmio.

Test Plan:
- Reset held 5 cycles then released -> o_led=6'b111111, o_rvalid=0; read 0x4 -> o_rdata=0 after 1 cycle.
- Write 0x0 with 0x0000002A, then read 0x0 -> o_led=6'b101010 next cycle; o_rdata=0x2A with o_rvalid one cycle after i_re.
- i_button low for 10 cycles then high (DEBOUNCE_CYCLES=16) -> STATUS bit0 stays 0, EVENT=0, count=0.
- i_button held low 100 cycles -> STATUS bit0=1 exactly 18 cycles after the edge; EVENT=1; STATUS[31:16]=1. Release -> bit0=0 and count stays 1.
- Write EVENT=1 in the same cycle as the debounced press edge -> EVENT reads 1. A later W1C alone -> EVENT reads 0.
- With GPIO_IRQ_EN: write IRQ_EN=1, then press -> o_irq=1 one cycle after EVENT sets; W1C -> o_irq=0 next cycle. Without the macro -> o_irq stays 0 and IRQ_EN reads 0.

Source files
------------

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared register offsets, bit indices and reset defaults for gpio_mmio
package gpio_pkg;

    localparam logic [3:0] ADDR_LED    = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_EVENT  = 4'h8;
    localparam logic [3:0] ADDR_IRQEN  = 4'hC;

    localparam int EVENT_BIT          = 0;
    localparam int STATUS_PRESSED_BIT = 0;
    localparam int STATUS_CNT_LSB     = 16;

    localparam logic [5:0] LED_RESET_DEFAULT = 6'b111111;

    // Word select: byte lanes within a register are not decoded.
    function automatic logic word_hit(input logic [3:0] addr, input logic [3:0] offset);
        return ({addr[3:2], 2'b00} == offset);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-flop synchroniser, stability counter, debounced pressed level and press pulse
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic button_i,
    output logic pressed_o,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          sample_pressed;

    // Button is active-low; flops idle at 1 so reset reads as released.
    assign sample_pressed = ~sync2_q;

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sample_pressed == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = ~db_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= button_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pressed_o = db_q;
    // Asserted in the cycle whose edge makes the debounced level go pressed.
    assign press_o   = db_d & ~db_q;

endmodule

// File: rtl/gpio_mmio.sv
// rtl/gpio_mmio.sv - memory-mapped GPIO: LED register, button status/event/press count; IRQ under GPIO_IRQ_EN
module gpio_mmio
    import gpio_pkg::*;
#(
    parameter int               LED_W           = 6,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter int               CNT_W           = 16,
    parameter logic [LED_W-1:0] LED_RESET       = LED_W'(LED_RESET_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       i_addr,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata,
    output logic             o_rvalid,
    input  logic             i_button,
    output logic [LED_W-1:0] o_led,
    output logic             o_irq
);

    logic             pressed;
    logic             press;
    logic             sel_led;
    logic             sel_status;
    logic             sel_event;
    logic             sel_irqen;
    logic [LED_W-1:0] led_q;
    logic [LED_W-1:0] led_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             event_q;
    logic             event_d;
    logic [31:0]      rd_mux;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;
    logic             rvalid_q;
    logic             irq_en_rd;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .button_i (i_button),
        .pressed_o(pressed),
        .press_o  (press)
    );

    assign sel_led    = word_hit(i_addr, ADDR_LED);
    assign sel_status = word_hit(i_addr, ADDR_STATUS);
    assign sel_event  = word_hit(i_addr, ADDR_EVENT);
    assign sel_irqen  = word_hit(i_addr, ADDR_IRQEN);

    // Read mux sees current register values, so a same-cycle write is not visible.
    always_comb begin
        rd_mux = '0;
        if (sel_led) begin
            rd_mux[LED_W-1:0] = led_q;
        end
        if (sel_status) begin
            rd_mux[STATUS_PRESSED_BIT]          = pressed;
            rd_mux[STATUS_CNT_LSB +: CNT_W]     = cnt_q;
        end
        if (sel_event) begin
            rd_mux[EVENT_BIT] = event_q;
        end
        if (sel_irqen) begin
            rd_mux[0] = irq_en_rd;
        end
    end

    always_comb begin
        led_d   = led_q;
        cnt_d   = cnt_q;
        event_d = event_q;
        rdata_d = i_re ? rd_mux : 32'd0;
        if (i_we && sel_led) begin
            led_d = i_wdata[LED_W-1:0];
        end
        if (i_we && sel_event && i_wdata[EVENT_BIT]) begin
            event_d = 1'b0;
        end
        // A press in the same cycle as W1C must survive.
        if (press) begin
            event_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q    <= LED_RESET;
            cnt_q    <= '0;
            event_q  <= 1'b0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
        end else begin
            led_q    <= led_d;
            cnt_q    <= cnt_d;
            event_q  <= event_d;
            rdata_q  <= rdata_d;
            rvalid_q <= i_re;
        end
    end

`ifdef GPIO_IRQ_EN
    logic irq_en_q;
    logic irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (i_we && sel_irqen) begin
                irq_en_q <= i_wdata[0];
            end
            irq_q <= event_q & irq_en_q;
        end
    end

    assign irq_en_rd = irq_en_q;
    assign o_irq     = irq_q;
`else
    assign irq_en_rd = 1'b0;
    assign o_irq     = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, i_addr[1:0], i_wdata[31:LED_W]};

    assign o_led    = led_q;
    assign o_rdata  = rdata_q;
    assign o_rvalid = rvalid_q;

endmodule

// File: tb/tb_gpio_mmio.sv
// tb/tb_gpio_mmio.sv - randomized self-checking bench for gpio_mmio against a cycle-level reference model
module tb_gpio_mmio;

    localparam int LED_W = 6;
    localparam int DC    = 16;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       i_addr;
    logic             i_we;
    logic             i_re;
    logic [31:0]      i_wdata;
    logic [31:0]      o_rdata;
    logic             o_rvalid;
    logic             i_button;
    logic [LED_W-1:0] o_led;
    logic             o_irq;

    always #5 clk = ~clk;

    gpio_mmio #(
        .LED_W          (LED_W),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (CNT_W),
        .LED_RESET      (6'b111111)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_addr  (i_addr),
        .i_we    (i_we),
        .i_re    (i_re),
        .i_wdata (i_wdata),
        .o_rdata (o_rdata),
        .o_rvalid(o_rvalid),
        .i_button(i_button),
        .o_led   (o_led),
        .o_irq   (o_irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: raw samples in flight, debounced level, disagreeing-sample run, registers.
    bit         m_s1, m_s2, m_db;
    int         m_run;
    bit [5:0]   m_led;
    bit         m_evt;
    int         m_cnt;
    bit         m_irqen, m_irq;
    bit [31:0]  m_rdata;
    bit         m_rvalid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] m_read(input logic [3:0] a);
        case (a[3:2])
            2'd0:    return {26'd0, m_led};
            2'd1:    return {16'(m_cnt), 15'd0, m_db};
            2'd2:    return {31'd0, m_evt};
`ifdef GPIO_IRQ_EN
            default: return {31'd0, m_irqen};
`else
            default: return 32'd0;
`endif
        endcase
    endfunction

    task automatic model_step();
        bit        press;
        bit [31:0] rd;
        press = 1'b0;
        if (reset) begin
            m_s1 = 1; m_s2 = 1; m_db = 0; m_run = 0;
            m_led = 6'b111111; m_evt = 0; m_cnt = 0;
            m_irqen = 0; m_irq = 0; m_rdata = 0; m_rvalid = 0;
        end else begin
            rd = m_read(i_addr);
            // A new level is accepted once DC consecutive synchronised samples disagree with it.
            if (bit'(!m_s2) != m_db) begin
                m_run = m_run + 1;
                if (m_run == DC) begin
                    m_db  = !m_db;
                    m_run = 0;
                    press = m_db;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = i_button;
            m_rvalid = i_re;
            m_rdata  = i_re ? rd : 32'd0;
`ifdef GPIO_IRQ_EN
            m_irq = m_evt & m_irqen;
`endif
            if (i_we) begin
                case (i_addr[3:2])
                    2'd0: m_led = i_wdata[5:0];
                    2'd2: if (i_wdata[0]) m_evt = 0;
`ifdef GPIO_IRQ_EN
                    2'd3: m_irqen = i_wdata[0];
`endif
                    default: ;
                endcase
            end
            if (press) begin
                m_evt = 1;
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("led", {26'd0, o_led}, {26'd0, m_led});
        check("rvalid", {31'd0, o_rvalid}, {31'd0, m_rvalid});
        check("rdata", o_rdata, m_rdata);
        check("irq", {31'd0, o_irq}, {31'd0, m_irq});
        i_we = 0;
        i_re = 0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        i_we = 1; i_addr = a; i_wdata = d;
        tick();
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        i_re = 1; i_addr = a;
        tick();
        d = o_rdata;
    endtask

    logic [31:0] rd;
    int          edges;
    int          c0;
    int          seg_left;

    initial begin
        reset = 1; i_addr = 0; i_we = 0; i_re = 0; i_wdata = 0; i_button = 1;
        @(posedge clk); #1;
        repeat (5) tick();
        reset = 0;
        check("rst_led", {26'd0, o_led}, 32'h3F);
        check("rst_rvalid", {31'd0, o_rvalid}, 32'd0);
        check("rst_irq", {31'd0, o_irq}, 32'd0);
        bus_read(4'h4, rd);
        check("rst_status", rd, 32'd0);
        check("rst_status_rvalid", {31'd0, o_rvalid}, 32'd1);

        bus_write(4'h0, 32'h0000_002A);
        check("led_2a", {26'd0, o_led}, 32'h2A);
        bus_read(4'h0, rd);
        check("led_read", rd, 32'h2A);
        bus_write(4'h4, 32'hFFFF_FFFF);
        bus_read(4'h4, rd);
        check("status_ro", rd, 32'd0);

        // Glitch shorter than the debounce window.
        i_button = 0;
        repeat (10) tick();
        i_button = 1;
        repeat (30) tick();
        bus_read(4'h4, rd);
        check("glitch_status", rd, 32'd0);
        bus_read(4'h8, rd);
        check("glitch_event", rd, 32'd0);

        // Press latency: debounced at edge DC+2, visible through a read one edge later.
        i_button = 0;
        edges = 0;
        do begin
            i_re = 1; i_addr = 4'h4;
            tick();
            edges++;
        end while (o_rdata[0] !== 1'b1 && edges < 200);
        check("press_latency", edges, DC + 3);
        repeat (100 - edges) tick();
        bus_read(4'h8, rd);
        check("press_event", rd, 32'd1);
        bus_read(4'h8, rd);
        check("event_read_no_clear", rd, 32'd1);
        bus_read(4'h4, rd);
        check("press_status", rd, 32'h0001_0001);
        i_button = 1;
        repeat (40) tick();
        bus_read(4'h4, rd);
        check("release_status", rd, 32'h0001_0000);

        // W1C coinciding with the press edge: set wins.
        bus_write(4'h8, 32'd1);
        bus_read(4'h8, rd);
        check("w1c_clear", rd, 32'd0);
        i_button = 0;
        repeat (DC + 1) tick();
        bus_write(4'h8, 32'd1);
        bus_read(4'h8, rd);
        check("w1c_vs_set", rd, 32'd1);
        i_button = 1;
        repeat (40) tick();
        bus_write(4'h8, 32'd1);
        bus_read(4'h8, rd);
        check("w1c_alone", rd, 32'd0);

`ifdef GPIO_IRQ_EN
        bus_write(4'hC, 32'd1);
        bus_read(4'hC, rd);
        check("irqen_read", rd, 32'd1);
        i_button = 0;
        repeat (DC + 2) tick();
        check("irq_not_yet", {31'd0, o_irq}, 32'd0);
        tick();
        check("irq_set", {31'd0, o_irq}, 32'd1);
        i_button = 1;
        repeat (30) tick();
        bus_write(4'h8, 32'd1);
        check("irq_hold", {31'd0, o_irq}, 32'd1);
        tick();
        check("irq_clear", {31'd0, o_irq}, 32'd0);
        bus_write(4'hC, 32'd0);
`else
        bus_write(4'hC, 32'd1);
        bus_read(4'hC, rd);
        check("irqen_absent", rd, 32'd0);
        i_button = 0;
        repeat (30) tick();
        i_button = 1;
        repeat (30) tick();
        check("irq_absent", {31'd0, o_irq}, 32'd0);
`endif

        // Counter wrap: 2^CNT_W presses return the count to its start.
        c0 = m_cnt;
        for (int p = 0; p < (1 << CNT_W); p++) begin
            i_button = 0;
            repeat (DC + 6) tick();
            i_button = 1;
            repeat (DC + 6) tick();
        end
        bus_read(4'h4, rd);
        check("cnt_wrap", {16'd0, rd[31:16]}, 32'((c0 + (1 << CNT_W)) % (1 << CNT_W)));

        // Random traffic with bouncing button and occasional reset.
        seg_left = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (seg_left == 0) begin
                i_button = 1'($urandom_range(0, 1));
                seg_left = $urandom_range(1, 40);
            end
            seg_left--;
            reset   = ($urandom_range(0, 499) == 0);
            i_addr  = 4'($urandom);
            i_wdata = $urandom;
            case ($urandom_range(0, 3))
                0: i_we = 1;
                1: i_re = 1;
                2: begin i_we = 1; i_re = 1; end
                default: ;
            endcase
            tick();
        end
        reset = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
